clock_mode_ctrl: RTL and testbench
==================================

# clock_mode_ctrl

User-interface mode controller for the digital clock. It turns four debounced front-panel keys into a three-mode sequence: RUN, time-set and alarm-set. It generates the per-field increment strobes for the timekeeping counters and the alarm block, plus that block's `alarm_active` and `save_alarm` controls. It sits between the key debouncers and the hour/minute/second counters and alarm unit, all clocked on the same 1 Hz tick.

## Interface
- `TIMEOUT`, default 30: number of idle ticks in a set mode before automatic return to RUN. Range 2..63.
- `CP_1Hz`  in  1  system tick clock; all logic on its rising edge.
- `_CR`  in  1  asynchronous active-low reset.
- `key_mode`  in  1  debounced level; a rising edge advances the mode.
- `key_sel`  in  1  debounced level; a rising edge advances the field.
- `key_adj`  in  1  debounced level; while high, the selected field is incremented once per tick.
- `key_save`  in  1  debounced level; a rising edge in alarm-set commits the alarm.
- `mode`  out  2  00 RUN, 01 TSET, 10 ASET; 11 is never driven.
- `field`  out  2  00 HOUR, 01 MIN, 10 SEC; 11 is never driven.
- `clock_hold`  out  1  high in TSET; freezes seconds counting.
- `time_set_hour`, `time_set_minute`, `time_set_second`  out  1 each  timekeeping increment strobes.
- `alarm_active`  out  1  alarm block edit enable.
- `set_hour`, `set_minute`, `set_second`  out  1 each  alarm increment strobes.
- `save_alarm`  out  1  single-tick alarm commit strobe.

## Operation
- Edge detect: one previous-sample register each for `key_mode`, `key_sel` and `key_save`. An edge means the current sample is 1 and the previous sample is 0. `key_adj` is used as a level.
- Mode FSM: a `key_mode` edge steps RUN→TSET→ASET→RUN.
  - Entering any mode forces `field` to HOUR.
  - Leaving ASET through a mode edge discards unsaved edits: no `save_alarm` is issued.
- Field: a `key_sel` edge steps HOUR→MIN→SEC→HOUR, but only in TSET or ASET. In RUN, `field` holds HOUR.
- Strobes, computed from the next-state values:
  - `time_set_X` = (next mode TSET) & `key_adj` & (next field == X) & no mode edge.
  - `set_X` = the same condition with next mode ASET.
  - At most one of the six strobes is high in any tick.
- Save:
  - A `key_save` edge while the current mode is ASET gives `save_alarm`=1 for exactly one tick. It is ignored in other modes.
  - `alarm_active` = (next mode ASET) | `save_alarm`. It is therefore high in the save tick even when a simultaneous mode edge leaves ASET.
- Priority within one tick:
  - A mode edge beats a sel edge and `key_adj`: field resets and no increment strobe is issued.
  - A save edge is honoured together with a mode edge.
  - A sel edge together with `key_adj`: the strobe goes to the new field.
- `clock_hold` = (next mode TSET).
- `mode` and `field` never take code 11. Any illegal value recovers to RUN/HOUR on the next tick.

## Timing
- All outputs are registered and update on the rising edge of `CP_1Hz`.
- Reset values, asserted asynchronously on `_CR` low: `mode`=RUN, `field`=HOUR, every strobe 0, `alarm_active`=0, `clock_hold`=0. The edge-detect registers clear to 0, so a key held high through reset release produces an edge on the first sample.
- Latency from key sample to output is one tick: a key high before edge n gives its effect in the outputs after edge n.
- A held `key_adj` produces one strobe per tick, continuously, with no auto-repeat delay.
- Reset mid-operation, including during a save tick: all outputs clear immediately, the pending save is lost, and no partial strobe appears.

## Configuration
- `CLK_MODE_TIMEOUT_EN` defined:
  - A 6-bit idle counter runs in TSET/ASET.
  - The counter clears on mode entry and on any tick where any key is high.
  - Otherwise it increments. When it reaches `TIMEOUT`−1, the next mode is RUN: field HOUR, no save, strobes 0.
  - The counter is held at 0 in RUN.
- `CLK_MODE_TIMEOUT_EN` undefined: the counter and parameter are unused, and set modes persist indefinitely.

## Test plan
- Reset, then `key_mode` high for 1 tick, 3 times → `mode` 01, 10, 00. `clock_hold` is 1 only in 01, and `alarm_active` is 1 only in 10.
- In TSET, `key_sel` pulse, then `key_adj` held 5 ticks → `field`=01 and `time_set_minute` high 5 consecutive ticks. Other strobes stay 0.
- In ASET, `key_adj` 3 ticks on HOUR, then a `key_save` pulse → `set_hour` high 3 ticks, then `save_alarm` high exactly 1 tick with `alarm_active`=1.
- In ASET, `key_mode` and `key_save` rise in the same tick → `save_alarm`=1 and `alarm_active`=1 that tick, `mode`=00 after it. The next tick has `alarm_active`=0.
- In TSET, `key_mode` and `key_adj` high in the same tick → `mode`=10, `field`=00, all strobes 0.
- With `CLK_MODE_TIMEOUT_EN` and `TIMEOUT`=30, enter ASET and leave keys idle → `mode` returns to 00 after 30 ticks with no `save_alarm`. Separately, pull `_CR` low mid-`key_adj` → all outputs 0 immediately.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Front-panel mode controller: RUN / time-set / alarm-set sequencing with registered increment and save strobes.
// Optional idle auto-return to RUN is enabled by defining CLK_MODE_TIMEOUT_EN.
module clock_mode_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       CP_1Hz,
    input  logic       _CR,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_adj,
    input  logic       key_save,
    output logic [1:0] mode,
    output logic [1:0] field,
    output logic       clock_hold,
    output logic       time_set_hour,
    output logic       time_set_minute,
    output logic       time_set_second,
    output logic       alarm_active,
    output logic       set_hour,
    output logic       set_minute,
    output logic       set_second,
    output logic       save_alarm
);
    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_TSET  = 2'b01;
    localparam logic [1:0] MODE_ASET  = 2'b10;
    localparam logic [1:0] FIELD_HOUR = 2'b00;
    localparam logic [1:0] FIELD_MIN  = 2'b01;
    localparam logic [1:0] FIELD_SEC  = 2'b10;

    if (TIMEOUT < 2 || TIMEOUT > 63) begin : g_timeout_range
        $error("clock_mode_ctrl: TIMEOUT out of range 2..63");
    end

    logic       r_mode_prev, r_sel_prev, r_save_prev;
    logic [1:0] r_mode, r_field;
    logic       r_hold, r_tsh, r_tsm, r_tss, r_aa, r_sh, r_sm, r_ss, r_save;
    logic       w_mode_edge, w_sel_edge, w_save_edge, w_timeout, w_adj_ok, w_save_nxt;
    logic [1:0] w_mode_nxt, w_field_nxt;

    assign w_mode_edge = key_mode & ~r_mode_prev;
    assign w_sel_edge  = key_sel  & ~r_sel_prev;
    assign w_save_edge = key_save & ~r_save_prev;

`ifdef CLK_MODE_TIMEOUT_EN
    localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT - 1);
    logic [5:0] r_idle;
    logic       w_any_key;

    assign w_any_key = key_mode | key_sel | key_adj | key_save;
    assign w_timeout = ((r_mode == MODE_TSET) || (r_mode == MODE_ASET)) && !w_any_key
                       && (r_idle == IDLE_LAST);

    // Idle tick counter: only advances while a set mode sits untouched
    always_ff @(posedge CP_1Hz or negedge _CR) begin
        if (!_CR) begin
            r_idle <= 6'd0;
        end else if ((w_mode_nxt == MODE_RUN) || w_any_key || (w_mode_nxt != r_mode)) begin
            r_idle <= 6'd0;
        end else begin
            r_idle <= r_idle + 6'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next mode/field; an illegal encoding in either register forces RUN/HOUR
    always_comb begin
        w_mode_nxt  = r_mode;
        w_field_nxt = r_field;
        if ((r_mode == 2'b11) || (r_field == 2'b11)) begin
            w_mode_nxt  = MODE_RUN;
            w_field_nxt = FIELD_HOUR;
        end else if (w_mode_edge) begin
            case (r_mode)
                MODE_RUN:  w_mode_nxt = MODE_TSET;
                MODE_TSET: w_mode_nxt = MODE_ASET;
                MODE_ASET: w_mode_nxt = MODE_RUN;
                default:   w_mode_nxt = MODE_RUN;
            endcase
            w_field_nxt = FIELD_HOUR;
        end else if (w_timeout) begin
            w_mode_nxt  = MODE_RUN;
            w_field_nxt = FIELD_HOUR;
        end else if (r_mode == MODE_RUN) begin
            w_field_nxt = FIELD_HOUR;
        end else if (w_sel_edge) begin
            case (r_field)
                FIELD_HOUR: w_field_nxt = FIELD_MIN;
                FIELD_MIN:  w_field_nxt = FIELD_SEC;
                FIELD_SEC:  w_field_nxt = FIELD_HOUR;
                default:    w_field_nxt = FIELD_HOUR;
            endcase
        end else begin
            w_field_nxt = r_field;
        end
    end

    // A mode edge in the same tick suppresses every increment strobe
    assign w_adj_ok   = key_adj & ~w_mode_edge;
    assign w_save_nxt = w_save_edge & (r_mode == MODE_ASET);

    // Key history for rising-edge detection
    always_ff @(posedge CP_1Hz or negedge _CR) begin
        if (!_CR) begin
            r_mode_prev <= 1'b0;
            r_sel_prev  <= 1'b0;
            r_save_prev <= 1'b0;
        end else begin
            r_mode_prev <= key_mode;
            r_sel_prev  <= key_sel;
            r_save_prev <= key_save;
        end
    end

    // State and registered output strobes, all derived from next-state values
    always_ff @(posedge CP_1Hz or negedge _CR) begin
        if (!_CR) begin
            r_mode  <= MODE_RUN;
            r_field <= FIELD_HOUR;
            r_hold  <= 1'b0;
            r_tsh   <= 1'b0;
            r_tsm   <= 1'b0;
            r_tss   <= 1'b0;
            r_aa    <= 1'b0;
            r_sh    <= 1'b0;
            r_sm    <= 1'b0;
            r_ss    <= 1'b0;
            r_save  <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_field <= w_field_nxt;
            r_hold  <= (w_mode_nxt == MODE_TSET);
            r_tsh   <= w_adj_ok & (w_mode_nxt == MODE_TSET) & (w_field_nxt == FIELD_HOUR);
            r_tsm   <= w_adj_ok & (w_mode_nxt == MODE_TSET) & (w_field_nxt == FIELD_MIN);
            r_tss   <= w_adj_ok & (w_mode_nxt == MODE_TSET) & (w_field_nxt == FIELD_SEC);
            r_aa    <= (w_mode_nxt == MODE_ASET) | w_save_nxt;
            r_sh    <= w_adj_ok & (w_mode_nxt == MODE_ASET) & (w_field_nxt == FIELD_HOUR);
            r_sm    <= w_adj_ok & (w_mode_nxt == MODE_ASET) & (w_field_nxt == FIELD_MIN);
            r_ss    <= w_adj_ok & (w_mode_nxt == MODE_ASET) & (w_field_nxt == FIELD_SEC);
            r_save  <= w_save_nxt;
        end
    end

    assign mode            = r_mode;
    assign field           = r_field;
    assign clock_hold      = r_hold;
    assign time_set_hour   = r_tsh;
    assign time_set_minute = r_tsm;
    assign time_set_second = r_tss;
    assign alarm_active    = r_aa;
    assign set_hour        = r_sh;
    assign set_minute      = r_sm;
    assign set_second      = r_ss;
    assign save_alarm      = r_save;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed vector bench for clock_mode_ctrl; idle-timeout sequence runs only when CLK_MODE_TIMEOUT_EN is defined.
module tb_clock_mode_ctrl;
    logic       CP_1Hz = 1'b0;
    logic       _CR;
    logic       key_mode, key_sel, key_adj, key_save;
    logic [1:0] mode, field;
    logic       clock_hold, time_set_hour, time_set_minute, time_set_second;
    logic       alarm_active, set_hour, set_minute, set_second, save_alarm;

    int checks = 0;
    int errors = 0;

    clock_mode_ctrl dut (
        .CP_1Hz(CP_1Hz), ._CR(_CR),
        .key_mode(key_mode), .key_sel(key_sel), .key_adj(key_adj), .key_save(key_save),
        .mode(mode), .field(field), .clock_hold(clock_hold),
        .time_set_hour(time_set_hour), .time_set_minute(time_set_minute),
        .time_set_second(time_set_second), .alarm_active(alarm_active),
        .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
        .save_alarm(save_alarm)
    );

    always #5 CP_1Hz = ~CP_1Hz;

    // keys = {mode, sel, adj, save}; flags = {hold, tsh, tsm, tss, aa, sh, sm, ss, save}
    typedef struct {
        logic [3:0] keys;
        logic [1:0] mode;
        logic [1:0] field;
        logic [8:0] flags;
    } vec_t;

    vec_t tv[$];

    function automatic logic [12:0] outs();
        return {mode, field, clock_hold, time_set_hour, time_set_minute, time_set_second,
                alarm_active, set_hour, set_minute, set_second, save_alarm};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic set_keys(input logic [3:0] k);
        {key_mode, key_sel, key_adj, key_save} = k;
    endtask

    initial begin
        _CR = 1'b0;
        set_keys(4'b0000);

        // RUN sequencing and mode flags
        tv.push_back('{4'b1000, 2'b01, 2'b00, 9'b1_000_0_000_0});
        tv.push_back('{4'b0000, 2'b01, 2'b00, 9'b1_000_0_000_0});
        tv.push_back('{4'b1000, 2'b10, 2'b00, 9'b0_000_1_000_0});
        tv.push_back('{4'b0000, 2'b10, 2'b00, 9'b0_000_1_000_0});
        tv.push_back('{4'b1000, 2'b00, 2'b00, 9'b0_000_0_000_0});
        tv.push_back('{4'b0000, 2'b00, 2'b00, 9'b0_000_0_000_0});
        // TSET: select minute, hold adj 5 ticks
        tv.push_back('{4'b1000, 2'b01, 2'b00, 9'b1_000_0_000_0});
        tv.push_back('{4'b0100, 2'b01, 2'b01, 9'b1_000_0_000_0});
        repeat (5) tv.push_back('{4'b0010, 2'b01, 2'b01, 9'b1_010_0_000_0});
        tv.push_back('{4'b0000, 2'b01, 2'b01, 9'b1_000_0_000_0});
        // sel edge with adj: strobe on new field; held sel is not a new edge
        tv.push_back('{4'b0110, 2'b01, 2'b10, 9'b1_001_0_000_0});
        tv.push_back('{4'b0110, 2'b01, 2'b10, 9'b1_001_0_000_0});
        tv.push_back('{4'b0000, 2'b01, 2'b10, 9'b1_000_0_000_0});
        // mode edge with adj in TSET: ASET/HOUR, no strobe
        tv.push_back('{4'b1010, 2'b10, 2'b00, 9'b0_000_1_000_0});
        repeat (3) tv.push_back('{4'b0010, 2'b10, 2'b00, 9'b0_000_1_100_0});
        tv.push_back('{4'b0001, 2'b10, 2'b00, 9'b0_000_1_000_1});
        tv.push_back('{4'b0000, 2'b10, 2'b00, 9'b0_000_1_000_0});
        // mode and save together: save honoured, alarm_active high that tick
        tv.push_back('{4'b1001, 2'b00, 2'b00, 9'b0_000_1_000_1});
        tv.push_back('{4'b0000, 2'b00, 2'b00, 9'b0_000_0_000_0});
        // save, sel, adj ignored in RUN
        tv.push_back('{4'b0001, 2'b00, 2'b00, 9'b0_000_0_000_0});
        tv.push_back('{4'b0100, 2'b00, 2'b00, 9'b0_000_0_000_0});
        tv.push_back('{4'b0010, 2'b00, 2'b00, 9'b0_000_0_000_0});
        tv.push_back('{4'b0000, 2'b00, 2'b00, 9'b0_000_0_000_0});
        // mode beats sel; then field wrap HOUR->MIN->SEC->HOUR; save ignored in TSET
        tv.push_back('{4'b1100, 2'b01, 2'b00, 9'b1_000_0_000_0});
        tv.push_back('{4'b0000, 2'b01, 2'b00, 9'b1_000_0_000_0});
        tv.push_back('{4'b0100, 2'b01, 2'b01, 9'b1_000_0_000_0});
        tv.push_back('{4'b0000, 2'b01, 2'b01, 9'b1_000_0_000_0});
        tv.push_back('{4'b0100, 2'b01, 2'b10, 9'b1_000_0_000_0});
        tv.push_back('{4'b0000, 2'b01, 2'b10, 9'b1_000_0_000_0});
        tv.push_back('{4'b0100, 2'b01, 2'b00, 9'b1_000_0_000_0});
        tv.push_back('{4'b0001, 2'b01, 2'b00, 9'b1_000_0_000_0});
        tv.push_back('{4'b0000, 2'b01, 2'b00, 9'b1_000_0_000_0});
        // ASET minute edit then leave without saving
        tv.push_back('{4'b1000, 2'b10, 2'b00, 9'b0_000_1_000_0});
        tv.push_back('{4'b0110, 2'b10, 2'b01, 9'b0_000_1_010_0});
        tv.push_back('{4'b1000, 2'b00, 2'b00, 9'b0_000_0_000_0});
        tv.push_back('{4'b0000, 2'b00, 2'b00, 9'b0_000_0_000_0});

        #2;
        check("reset", outs(), 13'd0);
        @(negedge CP_1Hz);
        _CR = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            set_keys(tv[i].keys);
            @(negedge CP_1Hz);
            check($sformatf("vec%0d", i), outs(), {tv[i].mode, tv[i].field, tv[i].flags});
        end

        // Reset asserted while adj is strobing time_set_hour
        set_keys(4'b1000);
        @(negedge CP_1Hz);
        set_keys(4'b0010);
        @(negedge CP_1Hz);
        check("adj_before_reset", outs(), {2'b01, 2'b00, 9'b1_100_0_000_0});
        _CR = 1'b0;
        #1;
        check("async_reset", outs(), 13'd0);
        // key_mode held through reset release gives an edge on the first sample
        set_keys(4'b1000);
        @(negedge CP_1Hz);
        check("held_in_reset", outs(), 13'd0);
        _CR = 1'b1;
        @(negedge CP_1Hz);
        check("edge_after_release", outs(), {2'b01, 2'b00, 9'b1_000_0_000_0});
        @(negedge CP_1Hz);
        check("held_no_reedge", outs(), {2'b01, 2'b00, 9'b1_000_0_000_0});

`ifdef CLK_MODE_TIMEOUT_EN
        // Enter ASET and stay idle: RUN after 30 ticks, no save
        set_keys(4'b0000);
        @(negedge CP_1Hz);
        set_keys(4'b1000);
        @(negedge CP_1Hz);
        set_keys(4'b0000);
        repeat (29) @(negedge CP_1Hz);
        check("idle_29", outs(), {2'b10, 2'b00, 9'b0_000_1_000_0});
        @(negedge CP_1Hz);
        check("idle_timeout", outs(), 13'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
